// File: rtl/hilo_muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl_pkg
//
// Shared definitions for the HI/LO multiply/divide controller:
//   - bit positions of the one-hot md_op vector driven from ALUControl[7:0]
//   - controller FSM state encoding
//   - divide iteration count and counter width
//   - small two's-complement helpers used for magnitude and sign fixup
// ---------------------------------------------------------------------------
package hilo_muldiv_ctrl_pkg;

  // One-hot md_op layout: {mult, multu, div, divu, mfhi, mflo, mthi, mtlo}
  localparam int MD_MULT  = 7;
  localparam int MD_MULTU = 6;
  localparam int MD_DIV   = 5;
  localparam int MD_DIVU  = 4;
  localparam int MD_MFHI  = 3;
  localparam int MD_MFLO  = 2;
  localparam int MD_MTHI  = 1;
  localparam int MD_MTLO  = 0;

  // Radix-2 restoring divide retires one quotient bit per cycle.
  localparam int DIV_ITERS = 32;

  // Wide enough to hold DIV_ITERS and any legal multiplier latency.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Conditionally negate a 32-bit value (two's complement).
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Conditionally negate a 64-bit value (two's complement).
  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div.sv
// ---------------------------------------------------------------------------
// div_iter_u32
//
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// The operands are captured on start; DIV_ITERS iterations follow. done is
// high during the cycle in which the final iteration is being performed, and
// quotient/remainder present the result of that iteration, so a consumer can
// register the finished result on the same edge that retires the last bit.
//
// Ports:
//   clk        system clock
//   resetn     synchronous active-low reset
//   start      capture dividend/divisor and begin iterating
//   abort      stop an in-progress divide immediately (wins over start)
//   dividend   32-bit unsigned dividend
//   divisor    32-bit unsigned divisor (0 yields all-ones quotient, rem = dividend)
//   quotient   quotient after the current iteration (final when done=1)
//   remainder  remainder after the current iteration (final when done=1)
//   done       pulse during the last iteration
// ---------------------------------------------------------------------------
module div_iter_u32
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [CNT_W-1:0] count;
  logic [31:0]      rem;
  logic [31:0]      quo;
  logic [31:0]      dvsr;
  logic [32:0]      shifted;
  logic             fits;
  logic [31:0]      rem_next;
  logic [31:0]      quo_next;

  // One restoring step: bring the next dividend bit (MSB of quo) into the
  // partial remainder and subtract the divisor if it fits. The partial
  // remainder is always below the divisor, so after a successful subtract the
  // result fits back into 32 bits.
  always_comb begin
    shifted  = {rem, quo[31]};
    fits     = (shifted >= {1'b0, dvsr});
    rem_next = fits ? 32'(shifted - {1'b0, dvsr}) : shifted[31:0];
    quo_next = {quo[30:0], fits};
  end

  assign quotient  = quo_next;
  assign remainder = rem_next;
  assign done      = (count == CNT_W'(1)) & ~abort;

  // The quotient register doubles as the dividend shifter: dividend bits leave
  // at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
    end else if (abort) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(DIV_ITERS);
      rem   <= '0;
      quo   <= dividend;
      dvsr  <= divisor;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
      rem   <= rem_next;
      quo   <= quo_next;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl
//
// HI/LO multiply/divide sequencer for the 5-stage MIPS pipeline. Owns the
// architectural HI and LO registers, launches fixed-latency multiplies and
// 32-iteration divides for the instruction in EXE, stalls EXE until the result
// is ready, and services MFHI/MFLO/MTHI/MTLO. A flush (or the instruction
// vanishing from EXE) abandons an operation without touching HI/LO.
//
// Parameters:
//   MUL_LAT     multiplier pipeline depth in cycles (1..4)
//
// Ports:
//   clk         system clock
//   resetn      synchronous active-low reset
//   ex_valid    valid instruction present in EXE
//   flush       kill the EXE instruction (exception/eret)
//   md_op       one-hot {mult,multu,div,divu,mfhi,mflo,mthi,mtlo}
//   src_a       rs operand after forwarding
//   src_b       rt operand after forwarding
//   stall       hold IF/ID/EXE this cycle
//   busy        controller is not idle
//   hilo_rdata  HI for mfhi, LO for mflo, else 0
//   hi_o        architectural HI
//   lo_o        architectural LO
// ---------------------------------------------------------------------------
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
)
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic        flush,
  input  logic [7:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int SR_W = 64 * MUL_LAT;

  md_state_e        state;
  md_state_e        state_next;
  logic [CNT_W-1:0] cnt;

  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  logic [31:0]      mag_a;
  logic [31:0]      mag_b;
  logic [31:0]      raw_a;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero;

  logic [63:0]      mul_prod;
  logic [SR_W-1:0]  mul_sr;
  logic [SR_W-1:0]  mul_sr_next;

  logic             op_mult;
  logic             op_multu;
  logic             op_div;
  logic             op_divu;
  logic             op_mfhi;
  logic             op_mflo;
  logic             op_mthi;
  logic             op_mtlo;
  logic             op_signed;
  logic             is_md;
  logic             accept;
  logic             running;
  logic             abort_run;
  logic [31:0]      src_a_mag;
  logic [31:0]      src_b_mag;

  logic             div_start;
  logic             div_abort;
  logic             div_done;
  logic [31:0]      div_q;
  logic [31:0]      div_r;
  logic [31:0]      fix_q;
  logic [31:0]      fix_r;

  // Instruction decode and the accept/abort conditions shared by the FSM and
  // the datapath registers.
  assign op_mult   = md_op[MD_MULT];
  assign op_multu  = md_op[MD_MULTU];
  assign op_div    = md_op[MD_DIV];
  assign op_divu   = md_op[MD_DIVU];
  assign op_mfhi   = md_op[MD_MFHI];
  assign op_mflo   = md_op[MD_MFLO];
  assign op_mthi   = md_op[MD_MTHI];
  assign op_mtlo   = md_op[MD_MTLO];

  assign op_signed = op_mult | op_div;
  assign is_md     = ex_valid & (op_mult | op_multu | op_div | op_divu);
  assign accept    = (state == ST_IDLE) & is_md & ~flush;
  assign running   = (state == ST_MUL) || (state == ST_DIV);
  assign abort_run = running & (flush | ~ex_valid);

  // Both multiply and divide work on unsigned magnitudes; the sign is put
  // back afterwards. Unsigned ops never see a sign bit.
  assign src_a_mag = cond_neg32(src_a, op_signed & src_a[31]);
  assign src_b_mag = cond_neg32(src_b, op_signed & src_b[31]);

  // Next-state logic plus the pipeline-facing outputs. The stalled
  // instruction stays in EXE until DONE, where stall drops so it retires on
  // the same edge that commits HI/LO. Reset forces both outputs low at once.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    busy       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = (op_div | op_divu) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (abort_run) begin
          state_next = ST_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DIV: begin
        if (abort_run) begin
          state_next = ST_IDLE;
        end else if (div_done) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    stall = resetn & is_md & (state != ST_DONE) & ~flush;
    busy  = resetn & (state != ST_IDLE);
  end

  // State register and the shared latency counter. The counter paces the
  // multiply; for a divide it tracks the remaining iterations alongside the
  // divider's own count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt <= (op_div | op_divu) ? CNT_W'(DIV_ITERS) : CNT_W'(MUL_LAT);
      end else if (running && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Operand capture on accept. The raw dividend is kept because a divide by
  // zero returns it untouched in HI, without any sign fixup.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mag_a  <= '0;
      mag_b  <= '0;
      raw_a  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
    end else if (accept) begin
      mag_a  <= src_a_mag;
      mag_b  <= src_b_mag;
      raw_a  <= src_a;
      sign_a <= op_signed & src_a[31];
      sign_b <= op_signed & src_b[31];
      b_zero <= (src_b == 32'd0);
    end
  end

  // Multiplier: the signed product is formed from the held magnitudes and
  // pushed through a MUL_LAT-deep shift chain. The result registers always
  // take the stage that is about to fall off the end, so after MUL_LAT cycles
  // in MUL they hold the product that entered on the first MUL cycle.
  assign mul_prod    = cond_neg64({32'd0, mag_a} * {32'd0, mag_b}, sign_a ^ sign_b);
  assign mul_sr_next = (mul_sr << 64) | SR_W'(mul_prod);

  // Divide sign fixup: quotient takes the XOR of the operand signs, the
  // remainder follows the dividend. Divide by zero bypasses the fixup.
  always_comb begin
    fix_q = cond_neg32(div_q, sign_a ^ sign_b);
    fix_r = cond_neg32(div_r, sign_a);
    if (b_zero) begin
      fix_q = 32'hFFFF_FFFF;
      fix_r = raw_a;
    end
  end

  // Result registers and multiplier chain.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mul_sr <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (state == ST_MUL) begin
      mul_sr           <= mul_sr_next;
      {res_hi, res_lo} <= mul_sr_next[SR_W-1 -: 64];
    end else if ((state == ST_DIV) && div_done && !abort_run) begin
      res_hi <= fix_r;
      res_lo <= fix_q;
    end
  end

  // Architectural HI/LO. Results commit on the DONE edge unless the
  // instruction is being flushed; moves-to write only from an idle
  // controller, which blocking issue guarantees for any mthi/mtlo.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_DONE) begin
      if (!flush) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if ((state == ST_IDLE) && ex_valid && !flush) begin
      if (op_mthi) begin
        hi <= src_a;
      end
      if (op_mtlo) begin
        lo <= src_a;
      end
    end
  end

  assign div_start = accept & (op_div | op_divu);
  assign div_abort = (state == ST_DIV) & abort_run;

  div_iter_u32 u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (src_a_mag),
    .divisor   (src_b_mag),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  assign hilo_rdata = op_mfhi ? hi : (op_mflo ? lo : 32'd0);
  assign hi_o       = hi;
  assign lo_o       = lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
//
// Directed bench for hilo_muldiv_ctrl with MUL_LAT=2. Inputs change 1 time
// unit after the rising edge; outputs are sampled 2 time units after it.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;

  localparam logic [7:0] OP_NONE  = 8'b0000_0000;
  localparam logic [7:0] OP_MULT  = 8'b1000_0000;
  localparam logic [7:0] OP_MULTU = 8'b0100_0000;
  localparam logic [7:0] OP_DIV   = 8'b0010_0000;
  localparam logic [7:0] OP_DIVU  = 8'b0001_0000;
  localparam logic [7:0] OP_MFHI  = 8'b0000_1000;
  localparam logic [7:0] OP_MFLO  = 8'b0000_0100;
  localparam logic [7:0] OP_MTHI  = 8'b0000_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0000_0001;

  logic        clk;
  logic        resetn;
  logic        ex_valid;
  logic        flush;
  logic [7:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall;
  logic        busy;
  logic [31:0] hilo_rdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int assertCount;
  int failCount;

  hilo_muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ex_valid   (ex_valid),
    .flush      (flush),
    .md_op      (md_op),
    .src_a      (src_a),
    .src_b      (src_b),
    .stall      (stall),
    .busy       (busy),
    .hilo_rdata (hilo_rdata),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every DUT input for the current cycle.
  task automatic applyStimulus(input logic v, input logic f, input logic [7:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    ex_valid = v;
    flush    = f;
    md_op    = op;
    src_a    = a;
    src_b    = b;
  endtask

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one multiply/divide, hold it in EXE while stalled, count the stall
  // cycles, then present followOp in the next cycle and check HI/LO there.
  task automatic runMd(input string tag, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int expStalls, input logic [31:0] expHi,
                       input logic [31:0] expLo, input logic [7:0] followOp);
    int stalls;
    stalls = 0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, op, a, b);
    #1;
    checkOutput({tag, "_idle_at_issue"}, 32'(busy), 32'd0);
    while ((stall === 1'b1) && (stalls < 200)) begin
      stalls++;
      @(posedge clk); #2;
    end
    checkOutput({tag, "_stall_cycles"}, 32'(stalls), 32'(expStalls));
    checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, followOp, 32'd0, 32'd0);
    #1;
    checkOutput({tag, "_hi"}, hi_o, expHi);
    checkOutput({tag, "_lo"}, lo_o, expLo);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    resetn      = 1'b0;

    // Reset with a multiply presented: nothing accepted, no stall.
    applyStimulus(1'b1, 1'b0, OP_MULT, 32'd5, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #2;
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_hi", hi_o, 32'd0);
    checkOutput("reset_lo", lo_o, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0);
    #1;
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    // Signed/unsigned multiply and divide, divide by zero.
    runMd("mult_neg",  OP_MULT,  32'hFFFF_FFFF, 32'd2,  3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, OP_NONE);
    runMd("multu",     OP_MULTU, 32'hFFFF_FFFF, 32'd2,  3, 32'h0000_0001, 32'hFFFF_FFFE, OP_NONE);
    runMd("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, OP_NONE);
    runMd("divu",      OP_DIVU,  32'hFFFF_FFF9, 32'd2, 33, 32'h0000_0001, 32'h7FFF_FFFC, OP_NONE);
    runMd("divu_zero", OP_DIVU,  32'h1234_5678, 32'd0, 33, 32'h1234_5678, 32'hFFFF_FFFF, OP_NONE);

    // Flush on stall cycle 10 of a divide leaves HI/LO untouched.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, OP_MTHI, 32'h1111_1111, 32'd0);
    #1;
    checkOutput("mthi_no_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, OP_MTLO, 32'h1111_1111, 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, OP_DIV, 32'd100, 32'd7);
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk); #1;
    end
    #1;
    checkOutput("div_stall_cycle10", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0);
    #1;
    checkOutput("flush_busy_next", 32'(busy), 32'd0);
    checkOutput("flush_hi_kept", hi_o, 32'h1111_1111);
    checkOutput("flush_lo_kept", lo_o, 32'h1111_1111);
    runMd("mult_after_flush", OP_MULT, 32'd7, 32'd6, 3, 32'd0, 32'h0000_002A, OP_NONE);

    // Multiply immediately followed by mflo sees the new LO.
    runMd("mult_3x5", OP_MULT, 32'd3, 32'd5, 3, 32'd0, 32'h0000_000F, OP_MFLO);
    checkOutput("mflo_after_mult", hilo_rdata, 32'h0000_000F);
    checkOutput("mflo_no_stall", 32'(stall), 32'd0);

    // mthi then mfhi on the next cycle.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    #1;
    checkOutput("mthi2_no_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, OP_MFHI, 32'd0, 32'd0);
    #1;
    checkOutput("mfhi_rdata", hilo_rdata, 32'hDEAD_BEEF);
    checkOutput("mfhi_no_stall", 32'(stall), 32'd0);

    // Reset during divide iteration 20 discards the divide and clears HI/LO.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, OP_DIV, 32'd1000, 32'd3);
    for (int i = 2; i <= 21; i++) begin
      @(posedge clk); #1;
    end
    #1;
    checkOutput("div_busy_iter20", 32'(busy), 32'd1);
    checkOutput("hi_before_reset", hi_o, 32'hDEAD_BEEF);
    resetn = 1'b0;
    #1;
    checkOutput("reset_mid_div_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0);
    #1;
    checkOutput("after_reset_busy", 32'(busy), 32'd0);
    checkOutput("after_reset_stall", 32'(stall), 32'd0);
    checkOutput("after_reset_hi", hi_o, 32'd0);
    checkOutput("after_reset_lo", lo_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Sequences the HI/LO multiply/divide resource for the 5-stage MIPS pipeline.
- Owns the HI and LO registers.
- Launches fixed-latency multiplies and 32-iteration divides for the MULT/MULTU/DIV/DIVU instructions in EXE, and holds EXE stalled until the result is ready.
- Services MFHI/MFLO/MTHI/MTLO, and aborts cleanly on pipeline flush.

Parameters:
MUL_LAT, 2, multiplier pipeline depth in cycles (legal 1..4)

Ports:
clk  input  1  system clock
resetn  input  1  reset, synchronous, active-low
ex_valid  input  1  valid instruction present in EXE
flush  input  1  kill the EXE instruction (exception/eret)
md_op  input  8  one-hot {mult,multu,div,divu,mfhi,mflo,mthi,mtlo} from ALUControl bits [7:0]
src_a  input  32  rs operand after forwarding
src_b  input  32  rt operand after forwarding
stall  output  1  hold IF/ID/EXE this cycle
busy  output  1  state != IDLE
hilo_rdata  output  32  HI for mfhi, LO for mflo, else 0
hi_o  output  32  architectural HI
lo_o  output  32  architectural LO

Behaviour:
- Clock and reset: one clock domain, clk. resetn is synchronous and active-low. While resetn=0: state=IDLE, HI=LO=0, counter=0, internal result regs=0, busy=0, stall=0. Reset mid-operation discards the operation.
- States: IDLE, MUL, DIV, DONE.
- Define is_md = ex_valid & (mult|multu|div|divu).
- IDLE:
  - is_md & !flush: latch operand magnitudes and signs (signed ops only), load counter, go to MUL (counter=MUL_LAT) or DIV (counter=32).
  - stall=1 in this accept cycle.
- MUL: counter decrements; go to DONE at 0. Product = 64-bit signed (mult) or unsigned (multu) product of src_a × src_b. Result is held internally as {res_hi,res_lo}.
- DIV: one restoring radix-2 iteration per cycle, unsigned on magnitudes. After 32 iterations, apply sign fixup:
  - quotient negated if sign_a^sign_b;
  - remainder negated if sign_a.
  - Then go to DONE. res_lo=quotient, res_hi=remainder.
- Divide by zero: no trap, same 33-cycle duration. res_lo=0xFFFFFFFF, res_hi=src_a raw (no sign fixup).
- DONE:
  - stall=0, so the instruction leaves EXE at this edge.
  - At this edge, if !flush: HI<=res_hi, LO<=res_lo.
  - Always return to IDLE.
- stall = is_md & (state != DONE) & !flush.
  - Stall cycles: 1+MUL_LAT for multiply, 33 for divide.
- flush or ex_valid=0 while in MUL/DIV: next state IDLE, HI/LO unchanged, stall=0 in that cycle.
- flush in IDLE: nothing accepted.
- MTHI/MTLO: in IDLE with ex_valid & !flush, HI (or LO) <= src_a at the clock edge. No stall.
- MFHI/MFLO: hilo_rdata is a combinational read of the HI/LO registers.
  - Never stalls; blocking issue guarantees no op is in flight.
  - An mfhi that immediately follows a mult reads the new value, because HI/LO commit on the DONE edge.
- Only one op in flight. is_md present while busy is the same stalled instruction, never a new issue.

Decomposition:
- global_define.vh: md_op bit indices (MD_MULT..MD_MTLO), state encodings, DIV_ITERS=32.
- Sub-module div_iter_u32: unsigned restoring divider.
  - Inputs: start, dividend, divisor, abort.
  - Outputs: quotient, remainder, done pulse after 32 cycles.
- Multiplier: inline pipeline register chain of depth MUL_LAT.

Test Plan:
- MULT a=0xFFFFFFFF, b=2, MUL_LAT=2 -> stall high 3 cycles, low in DONE; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU, same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 33 stall cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- DIVU a=0x12345678, b=0 -> 33 stall cycles; LO=0xFFFFFFFF, HI=0x12345678.
- HI=LO=0x11111111, start DIV, assert flush on stall cycle 10 -> stall=0 that cycle, IDLE next cycle, HI/LO still 0x11111111. A MULT accepted in the following cycle completes normally.
- MTHI 0xDEADBEEF, then MFHI next cycle -> hilo_rdata=0xDEADBEEF, no stall.
- MULT 3×5 immediately followed by MFLO -> hilo_rdata=0x0000000F.
- resetn=0 for one cycle during DIV iteration 20 -> busy=0, stall=0, HI=LO=0 the next cycle.
